// File: rtl/regfile_pkg.sv
// Shared constants and types for the scoreboarded register file.
// Holds default widths and the register-index / data typedefs.
package regfile_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 2;

  typedef logic [ADDR_W-1:0] ridx_t;
  typedef logic [DATA_W-1:0] rdata_t;

endpackage

// File: rtl/regfile_sb_scoreboard.sv
// rf_scoreboard: pending-write bits and registered popcount.
// Ports: clk_i, rst_ni, issue_valid_i/issue_dst_i, wb_en_i/wb_idx_i,
//        pending_o (one bit per register), pend_cnt_o.
module rf_scoreboard #(
  parameter int ADDR_W = regfile_pkg::ADDR_W
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                issue_valid_i,
  input  logic [ADDR_W-1:0]   issue_dst_i,
  input  logic                wb_en_i,
  input  logic [ADDR_W-1:0]   wb_idx_i,
  output logic [2**ADDR_W-1:0] pending_o,
  output logic [ADDR_W:0]     pend_cnt_o
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0] pending_q;
  logic [DEPTH-1:0] pending_d;
  logic [ADDR_W:0]  cnt_q;
  logic [ADDR_W:0]  cnt_d;

  // Clear on writeback first, then set on issue, so a
  // same-index collision leaves the bit set.
  always_comb begin
    pending_d = pending_q;
    if (wb_en_i && wb_idx_i != '0)
      pending_d[wb_idx_i] = 1'b0;
    if (issue_valid_i && issue_dst_i != '0)
      pending_d[issue_dst_i] = 1'b1;
    pending_d[0] = 1'b0;
    cnt_d = '0;
    for (int i = 1; i < DEPTH; i++)
      cnt_d = cnt_d + {{ADDR_W{1'b0}}, pending_d[i]};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q <= '0;
      cnt_q     <= '0;
    end else begin
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
    end
  end

  assign pending_o  = pending_q;
  assign pend_cnt_o = cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: 2R/1W register file with a pending-write scoreboard.
// Ports: clock, reset_n, rr1/rr2 -> rd1/rd2 and rr1_busy/rr2_busy,
//        regwrite/wr/wd writeback, issue_valid/issue_dst, pend_cnt.
// Optional macro REGFILE_BYPASS_EN forwards wd to reads of wr.
module regfile_sb #(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] rr1,
  input  logic [ADDR_W-1:0] rr2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              regwrite,
  input  logic [ADDR_W-1:0] wr,
  input  logic [DATA_W-1:0] wd,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_dst,
  output logic              rr1_busy,
  output logic              rr2_busy,
  output logic [ADDR_W:0]   pend_cnt
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  pending;
  logic              wb_en;
  logic [DATA_W-1:0] st1;
  logic [DATA_W-1:0] st2;
  logic              hit1;
  logic              hit2;

  assign wb_en = regwrite && (wr != '0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
    end else if (wb_en) begin
      mem_q[wr] <= wd;
    end
  end

  rf_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_sb (
    .clk_i         (clock),
    .rst_ni        (reset_n),
    .issue_valid_i (issue_valid),
    .issue_dst_i   (issue_dst),
    .wb_en_i       (regwrite),
    .wb_idx_i      (wr),
    .pending_o     (pending),
    .pend_cnt_o    (pend_cnt)
  );

  assign st1 = (rr1 == '0) ? '0 : mem_q[rr1];
  assign st2 = (rr2 == '0) ? '0 : mem_q[rr2];

`ifdef REGFILE_BYPASS_EN
  assign hit1 = wb_en && (rr1 == wr);
  assign hit2 = wb_en && (rr2 == wr);
`else
  assign hit1 = 1'b0;
  assign hit2 = 1'b0;
`endif

  assign rd1 = hit1 ? wd : st1;
  assign rd2 = hit2 ? wd : st2;

  // A forwarded read is no longer waiting on its writer.
  assign rr1_busy = pending[rr1] & ~hit1;
  assign rr2_busy = pending[rr2] & ~hit2;

endmodule
